// File: rtl/fetch_buffer_pkg.sv
// Shared sizing defaults and FSM state encoding for the instruction fetch buffer.
package fetch_buffer_pkg;

  localparam int LINE_BYTES_DEF = 64;
  localparam int BUF_BYTES_DEF  = 128;
  localparam int WIN_BYTES_DEF  = 15;
  localparam int ADDR_W         = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_DISCARD = 2'd2
  } fb_state_t;

endpackage

// File: rtl/fetch_buffer_if.sv
// Redirect, icache and decoder handshake bundle around the fetch buffer.
// The master side is the fetch buffer itself; the slave side is its environment.
interface fetch_buffer_if
  import fetch_buffer_pkg::*;
#(
  parameter int LINE_BYTES = LINE_BYTES_DEF,
  parameter int WIN_BYTES  = WIN_BYTES_DEF
) ();

  logic                    redirect_valid;
  logic [ADDR_W-1:0]       redirect_rip;
  logic                    ic_req;
  logic [ADDR_W-1:0]       ic_addr;
  logic [8*LINE_BYTES-1:0] ic_rdata;
  logic                    ic_done;
  logic                    dec_valid;
  logic [8*WIN_BYTES-1:0]  dec_bytes;
  logic [ADDR_W-1:0]       dec_rip;
  logic                    dec_consume;
  logic [7:0]              dec_len;

  modport master (
    input  redirect_valid, redirect_rip, ic_rdata, ic_done, dec_consume, dec_len,
    output ic_req, ic_addr, dec_valid, dec_bytes, dec_rip
  );

  modport slave (
    output redirect_valid, redirect_rip, ic_rdata, ic_done, dec_consume, dec_len,
    input  ic_req, ic_addr, dec_valid, dec_bytes, dec_rip
  );

endinterface

// File: rtl/fetch_align.sv
// Extracts the decode window starting at head from the circular byte store.
// Byte 0 of the window lands in the most significant byte.
module fetch_align
  import fetch_buffer_pkg::*;
#(
  parameter int BUF_BYTES = BUF_BYTES_DEF,
  parameter int WIN_BYTES = WIN_BYTES_DEF,
  localparam int PTR_W    = $clog2(BUF_BYTES)
) (
  input  logic [BUF_BYTES-1:0][7:0] mem,
  input  logic [PTR_W-1:0]          head,
  output logic [8*WIN_BYTES-1:0]    window
);

  // Gather WIN_BYTES bytes from head, wrapping naturally through the pointer width.
  always_comb begin
    window = '0;
    for (int i = 0; i < WIN_BYTES; i++) begin
      window[8*(WIN_BYTES-1-i) +: 8] = mem[head + PTR_W'(i)];
    end
  end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: requests icache lines ahead of the decoder and
// presents a byte-exact decode window at the current RIP.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | no line outstanding; fetch once a stream exists and room >= 1 line
// ST_FETCH   | line request outstanding; its data is appended on ic_done
// ST_DISCARD | stale request outstanding after a redirect; its data is dropped
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int LINE_BYTES = LINE_BYTES_DEF,
  parameter int BUF_BYTES  = BUF_BYTES_DEF,
  parameter int WIN_BYTES  = WIN_BYTES_DEF
) (
  input  logic            clk,
  input  logic            reset,
  fetch_buffer_if.master  bus
);

  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int PTR_W = $clog2(BUF_BYTES);
  localparam int CNT_W = $clog2(BUF_BYTES + 1);

  fb_state_t                state;
  logic                     ic_req_q;
  logic [ADDR_W-1:0]        ic_addr_q;
  logic [ADDR_W-1:0]        fetch_addr;
  logic [ADDR_W-1:0]        dec_rip_q;
  logic [PTR_W-1:0]         head;
  logic [PTR_W-1:0]         fill_ptr;
  logic [CNT_W-1:0]         count;
  logic                     first_line;
  logic [OFF_W-1:0]         first_off;
  logic                     stream_valid;
  logic [BUF_BYTES-1:0][7:0] mem;

  logic                     redirect;
  logic                     dec_valid;
  logic                     do_fill;
  logic                     do_consume;
  logic                     can_fetch;
  logic [OFF_W-1:0]         fill_off;
  logic [CNT_W-1:0]         fill_len;
  logic [CNT_W-1:0]         add_len;
  logic [CNT_W-1:0]         sub_len;
  logic [ADDR_W-1:0]        line_base;
  logic [8*WIN_BYTES-1:0]   window;

  // Redirect wins over both fill and consume; the first line after a
  // redirect only contributes the bytes from the target offset onward.
  always_comb begin
    redirect   = bus.redirect_valid;
    dec_valid  = (count >= CNT_W'(WIN_BYTES));
    do_fill    = (state == ST_FETCH) && bus.ic_done && !redirect;
    do_consume = bus.dec_consume && dec_valid && !redirect;
    can_fetch  = stream_valid && (count <= CNT_W'(LINE_BYTES));
    fill_off   = first_line ? first_off : '0;
    fill_len   = CNT_W'(LINE_BYTES) - CNT_W'(fill_off);
    add_len    = do_fill ? fill_len : '0;
    sub_len    = do_consume ? CNT_W'(bus.dec_len) : '0;
    line_base  = {bus.redirect_rip[ADDR_W-1:OFF_W], OFF_W'(0)};
  end

  // Fetch FSM plus queue pointers; ic_addr is latched per request so it
  // stays stable while a stale line is being drained in ST_DISCARD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      ic_req_q     <= 1'b0;
      ic_addr_q    <= '0;
      fetch_addr   <= '0;
      dec_rip_q    <= '0;
      head         <= '0;
      fill_ptr     <= '0;
      count        <= '0;
      first_line   <= 1'b0;
      first_off    <= '0;
      stream_valid <= 1'b0;
    end else if (redirect) begin
      count        <= '0;
      head         <= '0;
      fill_ptr     <= '0;
      dec_rip_q    <= bus.redirect_rip;
      fetch_addr   <= line_base;
      first_line   <= 1'b1;
      first_off    <= bus.redirect_rip[OFF_W-1:0];
      stream_valid <= 1'b1;
      ic_req_q     <= 1'b1;
      case (state)
        ST_IDLE: begin
          state     <= ST_FETCH;
          ic_addr_q <= line_base;
        end
        default: begin
          if (bus.ic_done) begin
            state     <= ST_FETCH;
            ic_addr_q <= line_base;
          end else begin
            state     <= ST_DISCARD;
          end
        end
      endcase
    end else begin
      count <= count + add_len - sub_len;
      if (do_consume) begin
        head      <= head + bus.dec_len[PTR_W-1:0];
        dec_rip_q <= dec_rip_q + ADDR_W'(bus.dec_len);
      end
      if (do_fill) begin
        fill_ptr   <= fill_ptr + fill_len[PTR_W-1:0];
        fetch_addr <= fetch_addr + ADDR_W'(LINE_BYTES);
        first_line <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (can_fetch) begin
            state     <= ST_FETCH;
            ic_req_q  <= 1'b1;
            ic_addr_q <= fetch_addr;
          end
        end
        ST_FETCH: begin
          if (bus.ic_done) begin
            state    <= ST_IDLE;
            ic_req_q <= 1'b0;
          end
        end
        ST_DISCARD: begin
          if (bus.ic_done) begin
            state     <= ST_FETCH;
            ic_addr_q <= fetch_addr;
          end
        end
        default: begin
          state    <= ST_IDLE;
          ic_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Byte store: append the useful part of an accepted line at the fill pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem <= '0;
    end else if (do_fill) begin
      for (int k = 0; k < LINE_BYTES; k++) begin
        if (OFF_W'(k) >= fill_off) begin
          mem[fill_ptr + PTR_W'(k) - PTR_W'(fill_off)] <= bus.ic_rdata[8*k +: 8];
        end
      end
    end
  end

  fetch_align #(
    .BUF_BYTES (BUF_BYTES),
    .WIN_BYTES (WIN_BYTES)
  ) u_align (
    .mem    (mem),
    .head   (head),
    .window (window)
  );

  assign bus.ic_req    = ic_req_q;
  assign bus.ic_addr   = ic_addr_q;
  assign bus.dec_valid = dec_valid;
  assign bus.dec_bytes = window;
  assign bus.dec_rip   = dec_rip_q;

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: redirects, fills, consumes, wrap and reset.
module tb_fetch_buffer;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fetch_buffer_if bus ();

  fetch_buffer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] make_line(input logic [7:0] base);
    logic [511:0] l;
    for (int k = 0; k < 64; k++) l[8*k +: 8] = base + 8'(k);
    return l;
  endfunction

  task automatic redirect_to(input logic [63:0] rip);
    bus.redirect_valid = 1'b1;
    bus.redirect_rip   = rip;
    tick();
    bus.redirect_valid = 1'b0;
  endtask

  task automatic line_done(input logic [7:0] base);
    bus.ic_done  = 1'b1;
    bus.ic_rdata = make_line(base);
    tick();
    bus.ic_done  = 1'b0;
  endtask

  task automatic consume(input logic [7:0] len);
    bus.dec_consume = 1'b1;
    bus.dec_len     = len;
    tick();
    bus.dec_consume = 1'b0;
  endtask

  initial begin
    reset              = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_rip   = '0;
    bus.ic_rdata       = '0;
    bus.ic_done        = 1'b0;
    bus.dec_consume    = 1'b0;
    bus.dec_len        = 8'd0;

    // reset state
    #3;
    check("rst_ic_req",    128'(bus.ic_req),    128'h0);
    check("rst_ic_addr",   128'(bus.ic_addr),   128'h0);
    check("rst_dec_valid", 128'(bus.dec_valid), 128'h0);
    check("rst_dec_bytes", 128'(bus.dec_bytes), 128'h0);
    check("rst_dec_rip",   128'(bus.dec_rip),   128'h0);
    tick();
    reset = 1'b0;
    tick(); tick(); tick();
    check("no_fetch_before_redirect", 128'(bus.ic_req), 128'h0);

    // redirect to 0x1000, line arrives three cycles later
    redirect_to(64'h1000);
    check("r1000_ic_req",    128'(bus.ic_req),    128'h1);
    check("r1000_ic_addr",   128'(bus.ic_addr),   128'h1000);
    check("r1000_dec_rip",   128'(bus.dec_rip),   128'h1000);
    check("r1000_dec_valid", 128'(bus.dec_valid), 128'h0);
    tick();
    check("r1000_req_held",  128'(bus.ic_req),    128'h1);
    line_done(8'h00);
    check("f1000_dec_valid", 128'(bus.dec_valid), 128'h1);
    check("f1000_dec_rip",   128'(bus.dec_rip),   128'h1000);
    check("f1000_dec_bytes", 128'(bus.dec_bytes), 128'h000102030405060708090A0B0C0D0E);
    check("f1000_req_drop",  128'(bus.ic_req),    128'h0);
    tick();
    check("next_req",        128'(bus.ic_req),    128'h1);
    check("next_addr",       128'(bus.ic_addr),   128'h1040);

    // redirect to 0x2000 while 0x1040 is outstanding: that line is discarded
    redirect_to(64'h2000);
    check("disc_req",        128'(bus.ic_req),    128'h1);
    check("disc_addr_stable",128'(bus.ic_addr),   128'h1040);
    check("disc_dec_valid",  128'(bus.dec_valid), 128'h0);
    check("disc_dec_rip",    128'(bus.dec_rip),   128'h2000);
    line_done(8'hA5);
    check("disc_new_addr",   128'(bus.ic_addr),   128'h2000);
    check("disc_dropped",    128'(bus.dec_valid), 128'h0);
    line_done(8'h40);
    check("f2000_dec_valid", 128'(bus.dec_valid), 128'h1);
    check("f2000_dec_rip",   128'(bus.dec_rip),   128'h2000);
    check("f2000_dec_bytes", 128'(bus.dec_bytes), 128'h404142434445464748494A4B4C4D4E);

    // consume 15 repeatedly; count 64 -> 49 while the next fetch starts
    consume(8'd15);
    check("c1_dec_rip",      128'(bus.dec_rip),   128'h200F);
    check("c1_dec_bytes",    128'(bus.dec_bytes), 128'h4F505152535455565758595A5B5C5D);
    check("c1_ic_req",       128'(bus.ic_req),    128'h1);
    check("c1_ic_addr",      128'(bus.ic_addr),   128'h2040);
    consume(8'd15);
    check("c2_dec_rip",      128'(bus.dec_rip),   128'h201E);
    line_done(8'h80);
    check("f2040_req_drop",  128'(bus.ic_req),    128'h0);
    tick();
    check("no_fetch_cnt98",  128'(bus.ic_req),    128'h0);
    consume(8'd15);
    consume(8'd15);
    consume(8'd15);
    check("no_fetch_cnt68",  128'(bus.ic_req),    128'h0);
    consume(8'd15);
    check("fetch_cnt53",     128'(bus.ic_req),    128'h1);
    check("fetch_addr_2080", 128'(bus.ic_addr),   128'h2080);
    check("c6_dec_rip",      128'(bus.dec_rip),   128'h205A);
    check("c6_dec_bytes",    128'(bus.dec_bytes), 128'h9A9B9C9D9E9FA0A1A2A3A4A5A6A7A8);
    consume(8'd15);
    consume(8'd3);
    check("c8_dec_rip",      128'(bus.dec_rip),   128'h206C);

    // simultaneous consume 5 and fill with count 20 -> count 79
    bus.dec_consume = 1'b1;
    bus.dec_len     = 8'd5;
    line_done(8'hC0);
    bus.dec_consume = 1'b0;
    check("sim_dec_rip",     128'(bus.dec_rip),   128'h2071);
    check("sim_dec_bytes",   128'(bus.dec_bytes), 128'hB1B2B3B4B5B6B7B8B9BABBBCBDBEBF);
    check("sim_req_drop",    128'(bus.ic_req),    128'h0);
    consume(8'd10);
    check("wrap_dec_rip",    128'(bus.dec_rip),   128'h207B);
    check("wrap_dec_bytes",  128'(bus.dec_bytes), 128'hBBBCBDBEBFC0C1C2C3C4C5C6C7C8C9);
    consume(8'd5);
    check("no_fetch_cnt69",  128'(bus.ic_req),    128'h0);
    tick();
    check("fetch_cnt64",     128'(bus.ic_req),    128'h1);
    check("fetch_addr_20c0", 128'(bus.ic_addr),   128'h20C0);
    consume(8'd15);
    consume(8'd15);
    consume(8'd15);
    consume(8'd4);
    check("cnt15_dec_valid", 128'(bus.dec_valid), 128'h1);
    check("cnt15_dec_rip",   128'(bus.dec_rip),   128'h20B1);
    check("cnt15_dec_bytes", 128'(bus.dec_bytes), 128'hF1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);
    consume(8'd1);
    check("cnt14_dec_valid", 128'(bus.dec_valid), 128'h0);
    check("cnt14_dec_rip",   128'(bus.dec_rip),   128'h20B2);
    consume(8'd5);
    check("ignored_consume", 128'(bus.dec_rip),   128'h20B2);

    // redirect to 0x103A (offset 58) while 0x20C0 is outstanding
    redirect_to(64'h103A);
    check("r103a_addr_stable", 128'(bus.ic_addr), 128'h20C0);
    check("r103a_dec_rip",   128'(bus.dec_rip),   128'h103A);
    line_done(8'hE0);
    check("r103a_ic_addr",   128'(bus.ic_addr),   128'h1000);
    line_done(8'h00);
    check("off58_dec_valid", 128'(bus.dec_valid), 128'h0);
    check("off58_req_drop",  128'(bus.ic_req),    128'h0);
    tick();
    check("off58_next_addr", 128'(bus.ic_addr),   128'h1040);
    check("off58_next_req",  128'(bus.ic_req),    128'h1);
    line_done(8'h40);
    check("off58_valid2",    128'(bus.dec_valid), 128'h1);
    check("off58_dec_rip",   128'(bus.dec_rip),   128'h103A);
    check("off58_dec_bytes", 128'(bus.dec_bytes), 128'h3A3B3C3D3E3F404142434445464748);

    // reset in the middle of a fetch
    consume(8'd15);
    tick();
    check("pre_rst_req",     128'(bus.ic_req),    128'h1);
    check("pre_rst_addr",    128'(bus.ic_addr),   128'h1080);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_ic_req",    128'(bus.ic_req),    128'h0);
    check("mid_rst_dec_valid", 128'(bus.dec_valid), 128'h0);
    check("mid_rst_ic_addr",   128'(bus.ic_addr),   128'h0);
    check("mid_rst_dec_rip",   128'(bus.dec_rip),   128'h0);
    check("mid_rst_dec_bytes", 128'(bus.dec_bytes), 128'h0);
    tick();
    reset = 1'b0;
    line_done(8'h55);
    check("stray_done_req",   128'(bus.ic_req),    128'h0);
    check("stray_done_valid", 128'(bus.dec_valid), 128'h0);
    check("stray_done_bytes", 128'(bus.dec_bytes), 128'h0);
    tick(); tick();
    check("stray_done_idle",  128'(bus.ic_req),    128'h0);

    // fetch address wraps past 2^64
    redirect_to(64'hFFFF_FFFF_FFFF_FFC0);
    check("top_ic_addr",     128'(bus.ic_addr),   128'hFFFF_FFFF_FFFF_FFC0);
    line_done(8'h10);
    check("top_dec_rip",     128'(bus.dec_rip),   128'hFFFF_FFFF_FFFF_FFC0);
    check("top_dec_bytes",   128'(bus.dec_bytes), 128'h101112131415161718191A1B1C1D1E);
    tick();
    check("wrap_ic_req",     128'(bus.ic_req),    128'h1);
    check("wrap_ic_addr",    128'(bus.ic_addr),   128'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
